// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text overlay: requester ids, ROM geometry
// and the tag that follows a font-ROM access through its read latency.
package vga_text_pkg;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 6;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [ID_W-1:0] REQ_DATE  = ID_W'(0);
  localparam logic [ID_W-1:0] REQ_TIME  = ID_W'(1);
  localparam logic [ID_W-1:0] REQ_TIMER = ID_W'(2);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic logic [ID_W-1:0] onehot_to_id(input logic [N_REQ-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) id = ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set bit of elig searching upward from ptr,
// wrapping modulo N. Zero latency; no state.
module rr_picker #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     elig,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             found
);

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    // Outer loop walks priority order; inner loop maps the offset to a position.
    for (int o = 0; o < N; o++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && elig[j] && (j == ((int'(ptr) + o) % N))) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// Round-robin share of the font ROM among the text box renderers; request-to-rdata
// latency is ROM_LAT+2, one grant per cycle, requesters wait on gnt.
module font_rom_arbiter
  import vga_text_pkg::*;
#(
  parameter int N_REQ   = vga_text_pkg::N_REQ,
  parameter int ADDR_W  = vga_text_pkg::ADDR_W,
  parameter int SEL_W   = vga_text_pkg::SEL_W,
  parameter int DATA_W  = vga_text_pkg::DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*SEL_W-1:0]  req_sel,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic [SEL_W-1:0]        rom_sel,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ*DATA_W-1:0] rdata,
  output logic [N_REQ-1:0]        rvalid
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
  logic [SEL_W-1:0]        rom_sel_q, rom_sel_d;
  logic [N_REQ*DATA_W-1:0] rdata_q, rdata_d;
  logic [N_REQ-1:0]        rvalid_q, rvalid_d;

  // Stage 0 is concurrent with the registered ROM address; stage ROM_LAT lines up
  // with rom_data, so the exiting tag names the slice that data belongs to.
  tag_t tag_q [ROM_LAT+1];
  tag_t tag_d [ROM_LAT+1];

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pick;
  logic             found;
  tag_t             issue;
  tag_t             retire;

  // A requester already holding gnt is masked so one request level is served once.
  assign elig = req & ~gnt_q;

  rr_picker #(.N(N_REQ), .PTR_W(PTR_W)) u_picker (
    .elig  (elig),
    .ptr   (ptr_q),
    .gnt   (pick),
    .found (found)
  );

  assign retire = tag_q[ROM_LAT];

  always_comb begin
    ptr_d       = ptr_q;
    gnt_d       = pick;
    rom_addr_d  = rom_addr_q;
    rom_sel_d   = rom_sel_q;
    issue.valid = found;
    issue.id    = onehot_to_id(pick);
    rdata_d     = rdata_q;
    rvalid_d    = '0;

    if (found) begin
      rom_addr_d = req_addr[issue.id*ADDR_W +: ADDR_W];
      rom_sel_d  = req_sel[issue.id*SEL_W +: SEL_W];
      ptr_d      = (issue.id == PTR_W'(N_REQ-1)) ? '0 : issue.id + 1'b1;
    end

    tag_d[0] = issue;
    for (int k = 1; k <= ROM_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    if (retire.valid) begin
      rdata_d[retire.id*DATA_W +: DATA_W] = rom_data;
      rvalid_d[retire.id]                 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      gnt_q      <= '0;
      rom_addr_q <= '0;
      rom_sel_q  <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
      for (int k = 0; k <= ROM_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rom_addr_q <= rom_addr_d;
      rom_sel_q  <= rom_sel_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      for (int k = 0; k <= ROM_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign gnt      = gnt_q;
  assign rom_addr = rom_addr_q;
  assign rom_sel  = rom_sel_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench: three arbiters (ROM_LAT 1, 3, 4) share one stimulus stream, each
// with its own ROM model returning address XOR 0xA5.
module tb_font_rom_arbiter;
  import vga_text_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req;
  logic [17:0] req_addr;
  logic [8:0]  req_sel;

  logic [2:0]  gnt_w      [NI];
  logic [5:0]  rom_addr_w [NI];
  logic [2:0]  rom_sel_w  [NI];
  logic [7:0]  rom_data_w [NI];
  logic [23:0] rdata_w    [NI];
  logic [2:0]  rvalid_w   [NI];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 4;
  endfunction

  function automatic logic [7:0] rom_word(input logic [5:0] a);
    return {2'b00, a} ^ 8'hA5;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    logic [7:0] pipe [LAT];

    always_ff @(posedge clk) begin
      pipe[0] <= {2'b00, rom_addr_w[g]} ^ 8'hA5;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign rom_data_w[g] = pipe[LAT-1];

    font_rom_arbiter #(.ROM_LAT(LAT)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_addr (req_addr),
      .req_sel  (req_sel),
      .gnt      (gnt_w[g]),
      .rom_addr (rom_addr_w[g]),
      .rom_sel  (rom_sel_w[g]),
      .rom_data (rom_data_w[g]),
      .rdata    (rdata_w[g]),
      .rvalid   (rvalid_w[g])
    );
  end

  task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lat=%0d observed=0x%0h expected=0x%0h", tag, lat_of(g), obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [2:0] s);
    req_addr[i*6 +: 6] = a;
    req_sel[i*3 +: 3]  = s;
  endtask

  task automatic chk_idle(input string tag);
    for (int g = 0; g < NI; g++) begin
      chk({tag, "_gnt"}, g, 32'(gnt_w[g]), 32'h0);
      chk({tag, "_rvalid"}, g, 32'(rvalid_w[g]), 32'h0);
      chk({tag, "_rdata"}, g, 32'(rdata_w[g]), 32'h0);
      chk({tag, "_rom_addr"}, g, 32'(rom_addr_w[g]), 32'h0);
      chk({tag, "_rom_sel"}, g, 32'(rom_sel_w[g]), 32'h0);
    end
  endtask

  int         cnt    [NI][3];
  int         last   [NI][3];
  int         maxgap [NI][3];
  int         issued_id   [40];
  logic [5:0] issued_addr [40];
  logic [5:0] cur_addr    [3];

  initial begin
    logic [2:0] eg;
    logic [2:0] ev;
    int         j;
    int         src;
    int         id;

    rst = 1'b1; req = '0; req_addr = '0; req_sel = '0;
    step(); step();
    chk_idle("reset");
    rst = 1'b0;

    // All three at once from ptr 0: grants 0,1,2 on consecutive cycles.
    set_req(0, 6'h01, 3'd1); set_req(1, 6'h12, 3'd3); set_req(2, 6'h3C, 3'd7);
    req = 3'b111;
    for (int c = 1; c <= 8; c++) begin
      step();
      eg = (c <= 3) ? 3'(1 << (c - 1)) : 3'b000;
      for (int g = 0; g < NI; g++) begin
        chk("all3_gnt", g, 32'(gnt_w[g]), 32'(eg));
        j  = c - lat_of(g) - 2;
        ev = (j >= 0 && j <= 2) ? 3'(1 << j) : 3'b000;
        chk("all3_rvalid", g, 32'(rvalid_w[g]), 32'(ev));
      end
      req = req & ~eg;
    end
    for (int g = 0; g < NI; g++) begin
      chk("all3_rdata", g, 32'(rdata_w[g]), 32'({rom_word(6'h3C), rom_word(6'h12), rom_word(6'h01)}));
      chk("all3_rom_sel", g, 32'(rom_sel_w[g]), 32'd7);
    end

    // Single request from requester 1.
    set_req(1, 6'h15, 3'd2); req = 3'b010;
    step();
    for (int g = 0; g < NI; g++) begin
      chk("single_gnt", g, 32'(gnt_w[g]), 32'b010);
      chk("single_rom_addr", g, 32'(rom_addr_w[g]), 32'h15);
      chk("single_rom_sel", g, 32'(rom_sel_w[g]), 32'd2);
    end
    req = '0;
    for (int c = 1; c <= 6; c++) begin
      step();
      for (int g = 0; g < NI; g++) begin
        chk("single_rvalid", g, 32'(rvalid_w[g]), (c == lat_of(g) + 1) ? 32'b010 : 32'b000);
        if (c == lat_of(g) + 1)
          chk("single_rdata", g, 32'(rdata_w[g]), 32'({rom_word(6'h3C), rom_word(6'h15), rom_word(6'h01)}));
      end
    end

    // Rotation: after requester 2, ptr wraps to 0 so 0 beats 1.
    set_req(2, 6'h2A, 3'd5); req = 3'b100;
    step();
    for (int g = 0; g < NI; g++) chk("rot_gnt2", g, 32'(gnt_w[g]), 32'b100);
    set_req(0, 6'h07, 3'd0); set_req(1, 6'h30, 3'd4); req = 3'b011;
    step();
    for (int g = 0; g < NI; g++) begin
      chk("rot_gnt0", g, 32'(gnt_w[g]), 32'b001);
      chk("rot_addr0", g, 32'(rom_addr_w[g]), 32'h07);
    end
    req = 3'b010;
    step();
    for (int g = 0; g < NI; g++) begin
      chk("rot_gnt1", g, 32'(gnt_w[g]), 32'b010);
      chk("rot_addr1", g, 32'(rom_addr_w[g]), 32'h30);
      chk("rot_sel1", g, 32'(rom_sel_w[g]), 32'd4);
    end
    req = '0;
    for (int c = 0; c < 6; c++) step();
    for (int g = 0; g < NI; g++)
      chk("rot_rdata", g, 32'(rdata_w[g]), 32'({rom_word(6'h2A), rom_word(6'h30), rom_word(6'h07)}));

    // Fairness: all held high 30 cycles, address changes on every grant; ptr starts at 2.
    for (int i = 0; i < 3; i++) begin
      cur_addr[i] = 6'(8 + i * 5);
      set_req(i, cur_addr[i], 3'(i));
      for (int g = 0; g < NI; g++) begin
        cnt[g][i] = 0; last[g][i] = 0; maxgap[g][i] = 0;
      end
    end
    req = 3'b111;
    for (int c = 1; c <= 36; c++) begin
      step();
      eg = (c <= 30) ? 3'(1 << ((c + 1) % 3)) : 3'b000;
      for (int g = 0; g < NI; g++) begin
        chk("fair_gnt", g, 32'(gnt_w[g]), 32'(eg));
        for (int i = 0; i < 3; i++) begin
          if (gnt_w[g][i]) begin
            if (last[g][i] != 0 && (c - last[g][i]) > maxgap[g][i]) maxgap[g][i] = c - last[g][i];
            last[g][i] = c;
            cnt[g][i]++;
          end
        end
        src = c - lat_of(g) - 1;
        if (src >= 1 && src <= 30) begin
          chk("fair_rvalid", g, 32'(rvalid_w[g]), 32'(1 << issued_id[src]));
          chk("fair_rdata", g, 32'(rdata_w[g][issued_id[src]*8 +: 8]), 32'(rom_word(issued_addr[src])));
        end else begin
          chk("fair_rvalid_idle", g, 32'(rvalid_w[g]), 32'h0);
        end
      end
      if (c <= 30) begin
        id = (c + 1) % 3;
        issued_id[c]   = id;
        issued_addr[c] = cur_addr[id];
        cur_addr[id]   = 6'((c * 7 + id * 13) & 63);
        set_req(id, cur_addr[id], 3'(id));
      end
      if (c == 30) req = '0;
    end
    for (int g = 0; g < NI; g++) begin
      for (int i = 0; i < 3; i++) begin
        chk("fair_count", g, 32'(cnt[g][i]), 32'd10);
        chk("fair_maxgap", g, 32'(maxgap[g][i]), 32'd3);
      end
    end

    // Reset the cycle after a grant: in-flight tag must never produce rvalid.
    set_req(2, 6'h11, 3'd1); req = 3'b100;
    step();
    for (int g = 0; g < NI; g++) chk("rst_pre_gnt", g, 32'(gnt_w[g]), 32'b100);
    req = '0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("rst_now");
    for (int c = 0; c < 6; c++) begin
      step();
      chk_idle("rst_after");
    end

    // Post-reset ptr is 0; then a lone requester is paced by the grant mask.
    set_req(0, 6'h22, 3'd6); set_req(2, 6'h05, 3'd2); req = 3'b101;
    step();
    for (int g = 0; g < NI; g++) chk("post_rst_gnt0", g, 32'(gnt_w[g]), 32'b001);
    req = 3'b100;
    step();
    for (int g = 0; g < NI; g++) chk("post_rst_gnt2", g, 32'(gnt_w[g]), 32'b100);
    req = 3'b001;
    for (int c = 0; c < 5; c++) begin
      step();
      for (int g = 0; g < NI; g++)
        chk("solo_pace", g, 32'(gnt_w[g]), (c % 2 == 0) ? 32'b001 : 32'b000);
    end
    req = '0;
    for (int c = 0; c < 6; c++) step();
    for (int g = 0; g < NI; g++)
      chk("post_rst_rdata", g, 32'(rdata_w[g]), 32'({rom_word(6'h05), 8'h00, rom_word(6'h22)}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
